// File: rtl/ik_iter_ctrl_if.sv
// Host and solver handshake bundle for ik_iter_ctrl.
// The controller side uses master and the host/solver side uses slave.
interface ik_iter_ctrl_if #(
  parameter int W        = 36,
  parameter int N_JOINT  = 6,
  parameter int MAX_ITER = 64
);
  localparam int IW = $clog2(MAX_ITER + 1);

  logic                   start;
  logic                   abort;
  logic [N_JOINT*W-1:0]   theta_init;
  logic [N_JOINT*W-1:0]   target;
  logic                   ik_en;
  logic                   ik_done;
  logic [N_JOINT*W-1:0]   ik_dh_dyn_in;
  logic [N_JOINT*W-1:0]   ik_target;
  logic [N_JOINT*W-1:0]   ik_dh_dyn_out;
  logic [N_JOINT*W-1:0]   ik_delta;
  logic                   busy;
  logic                   result_valid;
  logic                   converged;
  logic                   error;
  logic [IW-1:0]          iter_count;
  logic [N_JOINT*W-1:0]   dh_result;

  modport master (
    input  start, abort, theta_init, target, ik_done, ik_dh_dyn_out, ik_delta,
    output ik_en, ik_dh_dyn_in, ik_target, busy, result_valid, converged, error,
           iter_count, dh_result
  );

  modport slave (
    output start, abort, theta_init, target, ik_done, ik_dh_dyn_out, ik_delta,
    input  ik_en, ik_dh_dyn_in, ik_target, busy, result_valid, converged, error,
           iter_count, dh_result
  );
endinterface

// File: rtl/ik_iter_ctrl.sv
// Iteration sequencer for the ik_swift solver: relaunches solver passes until every
// joint delta is under THRESH, MAX_ITER passes have run, or the WAIT watchdog expires.
module ik_iter_ctrl #(
  parameter int           W        = 36,
  parameter int           N_JOINT  = 6,
  parameter int           MAX_ITER = 64,
  parameter logic [W-1:0] THRESH   = W'(66),
  parameter int           TIMEOUT  = 512
) (
  input logic            clk,
  input logic            rst,
  ik_iter_ctrl_if.master bus
);
  localparam int IW  = $clog2(MAX_ITER + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int VW  = N_JOINT * W;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [VW-1:0]   dh_cur;
  logic [VW-1:0]   tgt_reg;
  logic [VW-1:0]   delta_reg;
  logic [VW-1:0]   dh_result;
  logic [IW-1:0]   iter_count;
  logic [WDW-1:0]  watchdog;
  logic            result_valid;
  logic            converged;
  logic            error;
  logic            all_conv;
  logic            wd_expired;
  logic            ik_en;
  logic            busy;

  // Magnitude with the most negative code clamped so it can never pass the threshold.
  function automatic logic [W-1:0] abs_sat(input logic signed [W-1:0] x);
    if (x == {1'b1, {(W-1){1'b0}}})
      return {1'b0, {(W-1){1'b1}}};
    else if (x < 0)
      return $unsigned(-x);
    else
      return $unsigned(x);
  endfunction

  always_comb begin
    all_conv = 1'b1;
    for (int j = 0; j < N_JOINT; j++)
      if (abs_sat($signed(delta_reg[j*W +: W])) >= THRESH) all_conv = 1'b0;
  end

  assign wd_expired = (watchdog == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // abort beats ik_done, and ik_done beats watchdog expiry.
  always_comb begin
    state_nxt = state;
    ik_en     = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        ik_en     = 1'b1;
        busy      = 1'b1;
        state_nxt = bus.abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        ik_en = 1'b1;
        busy  = 1'b1;
        if (bus.abort)        state_nxt = S_IDLE;
        else if (bus.ik_done) state_nxt = S_CHECK;
        else if (wd_expired)  state_nxt = S_DONE;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (bus.abort)                         state_nxt = S_IDLE;
        else if (all_conv)                     state_nxt = S_DONE;
        else if (iter_count == IW'(MAX_ITER))  state_nxt = S_DONE;
        else                                   state_nxt = S_LAUNCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dh_cur       <= '0;
      tgt_reg      <= '0;
      delta_reg    <= '0;
      dh_result    <= '0;
      iter_count   <= '0;
      watchdog     <= '0;
      result_valid <= 1'b0;
      converged    <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            dh_cur       <= bus.theta_init;
            tgt_reg      <= bus.target;
            iter_count   <= '0;
            result_valid <= 1'b0;
            converged    <= 1'b0;
            error        <= 1'b0;
          end
        end
        S_LAUNCH: begin
          if (bus.abort) begin
            result_valid <= 1'b0;
            converged    <= 1'b0;
            error        <= 1'b0;
          end else begin
            watchdog <= '0;
          end
        end
        S_WAIT: begin
          if (bus.abort) begin
            result_valid <= 1'b0;
            converged    <= 1'b0;
            error        <= 1'b0;
          end else if (bus.ik_done) begin
            dh_cur     <= bus.ik_dh_dyn_out;
            delta_reg  <= bus.ik_delta;
            iter_count <= iter_count + 1'b1;
          end else begin
            watchdog <= watchdog + 1'b1;
            if (wd_expired) begin
              error        <= 1'b1;
              result_valid <= 1'b1;
              dh_result    <= dh_cur;
            end
          end
        end
        S_CHECK: begin
          if (bus.abort) begin
            result_valid <= 1'b0;
            converged    <= 1'b0;
            error        <= 1'b0;
          end else if (all_conv) begin
            converged    <= 1'b1;
            result_valid <= 1'b1;
            dh_result    <= dh_cur;
          end else if (iter_count == IW'(MAX_ITER)) begin
            result_valid <= 1'b1;
            dh_result    <= dh_cur;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ik_en        = ik_en;
  assign bus.busy         = busy;
  assign bus.ik_dh_dyn_in = dh_cur;
  assign bus.ik_target    = tgt_reg;
  assign bus.result_valid = result_valid;
  assign bus.converged    = converged;
  assign bus.error        = error;
  assign bus.iter_count   = iter_count;
  assign bus.dh_result    = dh_result;
endmodule

// File: tb/tb_ik_iter_ctrl.sv
// Bench for ik_iter_ctrl: behavioural solver model plus a scoreboard of expected solve results.
`timescale 1ns/1ps
module tb_ik_iter_ctrl;
  localparam int W        = 36;
  localparam int NJ       = 6;
  localparam int MAX_ITER = 64;
  localparam int TIMEOUT  = 512;
  localparam int IW       = $clog2(MAX_ITER + 1);
  localparam int VW       = NJ * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ik_iter_ctrl_if #(.W(W), .N_JOINT(NJ), .MAX_ITER(MAX_ITER)) bus ();

  ik_iter_ctrl #(
    .W(W), .N_JOINT(NJ), .MAX_ITER(MAX_ITER), .THRESH(36'd66), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic          conv;
    logic          err;
    logic [IW-1:0] iter;
    logic [VW-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  // solver model controls (written only by the main sequence)
  int           mode      = 0;   // 0 normal, 1 never done, 2 min-negative delta on pass 1
  int           lat       = 3;
  int           conv_pass = 0;
  logic [W-1:0] conv_val  = 36'd10;
  // solver model state
  int           m_cnt   = 0;
  int           m_pass  = 0;
  bit           m_armed = 1'b1;
  // ik_en gap monitor
  int           gaps = 0, gap_bad = 0, lowrun = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input longint base, input longint stp);
    logic [VW-1:0] r;
    for (int j = 0; j < NJ; j++) r[j*W +: W] = W'(base + j * stp);
    return r;
  endfunction

  // solver pass: each joint moves by a fixed per-joint step
  function automatic logic [VW-1:0] step(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    for (int j = 0; j < NJ; j++) r[j*W +: W] = v[j*W +: W] + W'(256 * (j + 1));
    return r;
  endfunction

  // joint vector after n passes from theta, in closed form
  function automatic logic [VW-1:0] predict(input logic [VW-1:0] th, input int n);
    logic [VW-1:0] r;
    for (int j = 0; j < NJ; j++) r[j*W +: W] = th[j*W +: W] + W'(n * 256 * (j + 1));
    return r;
  endfunction

  function automatic logic [VW-1:0] delta_for(input int p);
    logic [VW-1:0] r;
    r = '0;
    if (mode == 2 && p == 1)
      r[W-1:0] = {1'b1, {(W-1){1'b0}}};
    else
      for (int j = 0; j < NJ; j++) r[j*W +: W] = (p == conv_pass) ? conv_val : W'(1000);
    return r;
  endfunction

  // Solver model: after lat cycles of ik_en it pulses ik_done, then waits for ik_en to drop.
  initial begin
    bus.ik_done       = 1'b0;
    bus.ik_dh_dyn_out = '0;
    bus.ik_delta      = '0;
    forever begin
      @(negedge clk);
      if (!bus.busy) m_pass = 0;
      if (!bus.ik_en) begin
        m_cnt = 0; m_armed = 1'b1; bus.ik_done = 1'b0;
      end else if (m_armed && mode != 1) begin
        m_cnt++;
        if (m_cnt == lat) begin
          m_pass++;
          bus.ik_done       = 1'b1;
          bus.ik_dh_dyn_out = step(bus.ik_dh_dyn_in);
          bus.ik_delta      = delta_for(m_pass);
          m_armed           = 1'b0;
        end
      end else begin
        bus.ik_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.busy && !bus.ik_en) lowrun++;
      else if (bus.busy && bus.ik_en && lowrun > 0) begin
        gaps++;
        if (lowrun != 1) gap_bad++;
        lowrun = 0;
      end else if (!bus.busy) lowrun = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "bench did not finish");
  end

  task automatic drive_start(input logic [VW-1:0] th, input logic [VW-1:0] tg);
    bus.theta_init = th;
    bus.target     = tg;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_result(input int budget, output int cyc);
    cyc = 0;
    while (!bus.result_valid && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.result_valid) chk("result_timeout", 0, 1);
  endtask

  task automatic push(input logic c, input logic e, input int it, input logic [VW-1:0] r);
    exp_t x;
    x.conv = c; x.err = e; x.iter = IW'(it); x.res = r;
    sb.push_back(x);
  endtask

  task automatic score(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_conv"}, bus.converged, e.conv);
    chk({tag, "_err"},  bus.error, e.err);
    chk({tag, "_iter"}, bus.iter_count, e.iter);
    chk({tag, "_res"},  bus.dh_result, e.res);
    chk({tag, "_en"},   bus.ik_en, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    logic [VW-1:0] th_a, th_b, th_c, tg_a, tg_b, prev;
    int cyc, g0, gb0;
    th_a = mkvec(65536, 65536);
    th_b = mkvec(-196608, 4096);
    th_c = mkvec(12345, -777);
    tg_a = mkvec(100, 7);
    tg_b = mkvec(-5000, 3);
    bus.start = 1'b0; bus.abort = 1'b0; bus.theta_init = '0; bus.target = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_en", bus.ik_en, 0);
    chk("rst_rv", bus.result_valid, 0);
    chk("rst_iter", bus.iter_count, 0);
    chk("rst_flags", {bus.converged, bus.error}, 0);
    chk("rst_res", bus.dh_result, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: reset in the middle of a WAIT after two passes
    mode = 0; conv_pass = 0; lat = 3;
    drive_start(th_a, tg_a);
    chk("t1_tgt", bus.ik_target, tg_a);
    cyc = 0;
    while (!(bus.iter_count == 2 && bus.ik_en) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("t1_reach", bus.iter_count, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t1_en_async", bus.ik_en, 0);
    chk("t1_busy_async", bus.busy, 0);
    chk("t1_rv_async", bus.result_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t1_iter", bus.iter_count, 0);
    chk("t1_dhcur", bus.ik_dh_dyn_in, 0);
    chk("t1_tgt_clr", bus.ik_target, 0);

    // T2: converge on pass 3, one-cycle ik_en gap between passes
    mode = 0; conv_pass = 3; conv_val = 36'd10; lat = 3;
    push(1'b1, 1'b0, 3, predict(th_a, 3));
    g0 = gaps; gb0 = gap_bad;
    drive_start(th_a, tg_a);
    wait_result(200, cyc);
    score("t2");
    chk("t2_gaps", gaps - g0, 2);
    chk("t2_gap_len", gap_bad - gb0, 0);

    // T2b: |-65| is just under the threshold
    conv_pass = 2; conv_val = -36'sd65; lat = 4;
    push(1'b1, 1'b0, 2, predict(th_b, 2));
    drive_start(th_b, tg_b);
    wait_result(200, cyc);
    score("t2b");
    conv_val = 36'd10;

    // T3: never converges, stops after MAX_ITER passes
    conv_pass = 0; lat = 2;
    push(1'b0, 1'b0, MAX_ITER, predict(th_c, MAX_ITER));
    drive_start(th_c, tg_a);
    wait_result(1000, cyc);
    score("t3");

    // T4: solver never answers, watchdog ends the solve
    mode = 1;
    push(1'b0, 1'b1, 0, th_b);
    drive_start(th_b, tg_b);
    wait_result(TIMEOUT + 50, cyc);
    score("t4");
    chk("t4_latency", cyc, TIMEOUT + 1);

    // T6: most negative delta must not count as converged; the next pass converges
    mode = 2; conv_pass = 2; lat = 3;
    push(1'b1, 1'b0, 2, predict(th_a, 2));
    g0 = gaps;
    drive_start(th_a, tg_b);
    wait_result(200, cyc);
    score("t6");
    chk("t6_relaunch", gaps - g0, 1);

    // T5: start while busy is ignored
    mode = 0; conv_pass = 1; lat = 5;
    push(1'b1, 1'b0, 1, predict(th_a, 1));
    drive_start(th_a, tg_a);
    @(posedge clk); #1;
    bus.theta_init = th_b; bus.target = tg_b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("t5_busy", bus.busy, 1);
    chk("t5_tgt_kept", bus.ik_target, tg_a);
    chk("t5_dh_kept", bus.ik_dh_dyn_in, th_a);
    wait_result(200, cyc);
    score("t5");
    prev = bus.dh_result;

    // T5: abort in the same cycle as ik_done
    lat = 3;
    drive_start(th_b, tg_b);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!(m_armed && bus.ik_en && m_cnt == lat - 1) && cyc < 50);
    bus.abort = 1'b1;
    @(negedge clk); #1;
    chk("t5_done_with_abort", bus.ik_done, 1);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("t5_ab_busy", bus.busy, 0);
    chk("t5_ab_en", bus.ik_en, 0);
    chk("t5_ab_rv", bus.result_valid, 0);
    chk("t5_ab_flags", {bus.converged, bus.error}, 0);
    chk("t5_ab_iter", bus.iter_count, 0);
    chk("t5_ab_res", bus.dh_result, prev);
    @(posedge clk); #1;
    chk("t5_ab_idle", bus.busy, 0);

    // start and abort together while idle: start wins
    push(1'b1, 1'b0, 1, predict(th_c, 1));
    bus.abort = 1'b1;
    drive_start(th_c, tg_a);
    bus.abort = 1'b0;
    chk("t5_sa_busy", bus.busy, 1);
    wait_result(200, cyc);
    score("t5_sa");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
